// File: rtl/dma_periph_pkg.sv
// Shared types and constants for the DMA peripheral endpoint.
package dma_periph_pkg;

  // One-hot states so each phase of the DREQ/DACK handshake is a single flop.
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    XFER    = 4'b0100,
    RELEASE = 4'b1000
  } state_e;

  // Transfer direction as seen from memory.
  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

endpackage

// File: rtl/dma_periph_fifo.sv
// Synchronous byte FIFO with a single push port and a single pop port.
// The head entry is read combinationally so it can drive the DMA bus
// during the strobe without waiting an extra cycle.
module dma_periph_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dma_periph_endpoint.sv
// Peripheral side of the DREQ/DACK single-transfer DMA protocol. Bytes are
// buffered between a local valid/ready stream and the DMA data bus; one byte
// moves per DREQ, committed on the rising edge of the acknowledged strobe.
module dma_periph_endpoint
  import dma_periph_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CHANNEL = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic                   dirIn,
  output logic                   DREQ,
  input  logic [3:0]             DACK,
  input  logic                   IOR_N,
  input  logic                   IOW_N,
  input  logic                   EOP_N,
  input  logic [7:0]             busDataIn,
  output logic [7:0]             busDataOut,
  output logic                   busDataOutEn,
  input  logic                   devInValid,
  output logic                   devInReady,
  input  logic [7:0]             devInData,
  output logic                   devOutValid,
  input  logic                   devOutReady,
  output logic [7:0]             devOutData,
  output logic                   tcFlag,
  input  logic                   tcClear,
  output logic [$clog2(DEPTH):0] fifoCount
);

  localparam logic [1:0] CH_IDX = 2'(CHANNEL);

  state_e     state_q;
  logic       dreq_q;
  logic       dir_q, dir_d;
  logic       tc_q, tc_d;
  logic       strobe_q, strobe_d;
  logic       ack_q;
  logic       run_q;
  logic [7:0] cap_q, cap_d;

  logic       ack;
  logic       strobe_low_raw;
  logic       strobe;
  logic       in_service;
  logic       commit;
  logic       dev_in_fire;
  logic       dev_out_fire;
  logic       latch_ok;
  logic       ready;
  logic       go_req;

  logic       fifo_push;
  logic [7:0] fifo_push_data;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  assign ack            = DACK[CH_IDX];
  assign strobe_low_raw = (dir_q == DIR_DEV2MEM) ? !IOR_N : !IOW_N;
  assign strobe         = ack && strobe_low_raw;
  assign in_service     = (state_q == REQ) || (state_q == XFER);
  assign commit         = (state_q == XFER) && strobe_q && ack && !strobe_low_raw;

  assign devInReady   = run_q && (dir_q == DIR_DEV2MEM) && !fifo_full;
  assign devOutValid  = run_q && (dir_q == DIR_MEM2DEV) && !fifo_empty;
  assign devOutData   = fifo_head;
  assign dev_in_fire  = devInValid && devInReady;
  assign dev_out_fire = devOutValid && devOutReady;

  assign busDataOutEn = in_service && (dir_q == DIR_DEV2MEM) && strobe;
  assign busDataOut   = busDataOutEn ? fifo_head : 8'h00;
  assign DREQ         = dreq_q;
  assign tcFlag       = tc_q;

  // Direction only follows dirIn while idle and empty, and request readiness
  // uses that same effective direction so a switch never raises a bogus DREQ.
  always_comb begin
    latch_ok = (state_q == IDLE) && fifo_empty && !dev_in_fire;
    dir_d    = latch_ok ? dirIn : dir_q;
    ready    = (dir_d == DIR_DEV2MEM) ? !fifo_empty : !fifo_full;
    go_req   = enable && !tc_q && ready;
  end

  // Bus capture, strobe history and terminal-count next values; a set beats a clear.
  always_comb begin
    strobe_d = strobe;
    cap_d    = cap_q;
    if (in_service && (dir_q == DIR_MEM2DEV) && strobe) cap_d = busDataIn;
    tc_d = tc_q;
    if (tcClear) tc_d = 1'b0;
    if (!EOP_N && ack) tc_d = 1'b1;
  end

  // FIFO port steering: the DMA side and the local side swap roles with direction.
  always_comb begin
    if (dir_q == DIR_DEV2MEM) begin
      fifo_push      = dev_in_fire;
      fifo_push_data = devInData;
      fifo_pop       = commit;
    end else begin
      fifo_push      = commit;
      fifo_push_data = cap_q;
      fifo_pop       = dev_out_fire;
    end
  end

  // Handshake FSM with a registered DREQ so it never glitches on bus inputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      dreq_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go_req) begin
            state_q <= REQ;
            dreq_q  <= 1'b1;
          end
        end
        REQ: begin
          if (ack && strobe_low_raw) begin
            state_q <= XFER;
          end else if (ack_q && !ack) begin
            state_q <= IDLE;
            dreq_q  <= 1'b0;
          end
        end
        XFER: begin
          if (commit) begin
            state_q <= RELEASE;
            dreq_q  <= 1'b0;
          end else if (!ack) begin
            state_q <= IDLE;
            dreq_q  <= 1'b0;
          end
        end
        RELEASE: begin
          dreq_q <= 1'b0;
          if (!ack) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          dreq_q  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath and status registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dir_q    <= DIR_DEV2MEM;
      tc_q     <= 1'b0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      run_q    <= 1'b0;
      cap_q    <= 8'h00;
    end else begin
      dir_q    <= dir_d;
      tc_q     <= tc_d;
      strobe_q <= strobe_d;
      ack_q    <= ack;
      run_q    <= 1'b1;
      cap_q    <= cap_d;
    end
  end

  dma_periph_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifoCount),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_dma_periph_endpoint.sv
// Self-checking bench for dma_periph_endpoint. A queue holds the bytes the
// endpoint should be buffering; every expected value comes from that queue
// or from the protocol rules, never from the DUT.
module tb_dma_periph_endpoint;

  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       enable;
  logic       dirIn;
  logic       DREQ;
  logic [3:0] DACK;
  logic       IOR_N;
  logic       IOW_N;
  logic       EOP_N;
  logic [7:0] busDataIn;
  logic [7:0] busDataOut;
  logic       busDataOutEn;
  logic       devInValid;
  logic       devInReady;
  logic [7:0] devInData;
  logic       devOutValid;
  logic       devOutReady;
  logic [7:0] devOutData;
  logic       tcFlag;
  logic       tcClear;
  logic [3:0] fifoCount;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] model_q[$];
  bit         model_dir;

  dma_periph_endpoint #(.DEPTH(DEPTH), .CHANNEL(0)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .enable       (enable),
    .dirIn        (dirIn),
    .DREQ         (DREQ),
    .DACK         (DACK),
    .IOR_N        (IOR_N),
    .IOW_N        (IOW_N),
    .EOP_N        (EOP_N),
    .busDataIn    (busDataIn),
    .busDataOut   (busDataOut),
    .busDataOutEn (busDataOutEn),
    .devInValid   (devInValid),
    .devInReady   (devInReady),
    .devInData    (devInData),
    .devOutValid  (devOutValid),
    .devOutReady  (devOutReady),
    .devOutData   (devOutData),
    .tcFlag       (tcFlag),
    .tcClear      (tcClear),
    .fifoCount    (fifoCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic local_push(input logic [7:0] d);
    devInValid = 1'b1;
    devInData  = d;
    tick();
    devInValid = 1'b0;
    model_q.push_back(d);
  endtask

  task automatic set_dir(input bit d);
    enable = 1'b0;
    dirIn  = d;
    tick();
    tick();
    model_dir = d;
  endtask

  // One full DMA single transfer: wait for DREQ, strobe low two cycles, release.
  task automatic dma_cycle(input bit eop, input bit push_at_commit, input logic [7:0] wdata,
                           output logic [7:0] rdata, output logic en_seen,
                           output logic dreq_rel, output int cnt_after, output bit timeout);
    int n = 0;
    timeout = 0; rdata = '0; en_seen = 0; dreq_rel = 0; cnt_after = 0;
    while (!DREQ && n < 20) begin
      tick();
      n++;
    end
    if (!DREQ) begin
      timeout = 1;
      return;
    end
    DACK      = 4'b0001;
    EOP_N     = !eop;
    busDataIn = wdata;
    if (model_dir == 1'b0) IOR_N = 1'b0; else IOW_N = 1'b0;
    tick();
    rdata   = busDataOut;
    en_seen = busDataOutEn;
    EOP_N   = 1'b1;
    tick();
    IOR_N = 1'b1;
    IOW_N = 1'b1;
    if (push_at_commit) begin
      devInValid = 1'b1;
      devInData  = wdata;
    end
    tick();
    devInValid = 1'b0;
    dreq_rel   = DREQ;
    cnt_after  = int'(fifoCount);
    DACK       = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1; enable = 0; dirIn = 0; DACK = 0; IOR_N = 1; IOW_N = 1; EOP_N = 1;
    busDataIn = 0; devInValid = 0; devInData = 0; devOutReady = 0; tcClear = 0;
    model_q.delete(); model_dir = 0;
    tick(); tick();
    compared++; if (DREQ !== 1'b0) begin mismatched++; $display("FAIL reset_dreq: got %b expected 0", DREQ); end
    compared++; if (busDataOutEn !== 1'b0) begin mismatched++; $display("FAIL reset_outen: got %b expected 0", busDataOutEn); end
    compared++; if (busDataOut !== 8'h00) begin mismatched++; $display("FAIL reset_busout: got %h expected 00", busDataOut); end
    compared++; if (tcFlag !== 1'b0) begin mismatched++; $display("FAIL reset_tc: got %b expected 0", tcFlag); end
    compared++; if (fifoCount !== 4'd0) begin mismatched++; $display("FAIL reset_count: got %0d expected 0", fifoCount); end
    compared++; if (devInReady !== 1'b0) begin mismatched++; $display("FAIL reset_inready: got %b expected 0", devInReady); end
    compared++; if (devOutValid !== 1'b0) begin mismatched++; $display("FAIL reset_outvalid: got %b expected 0", devOutValid); end
    RESET = 1'b0;
    tick(); tick();
    compared++; if (devInReady !== 1'b1) begin mismatched++; $display("FAIL post_reset_inready: got %b expected 1", devInReady); end
  endtask

  task automatic test_dev2mem();
    logic [7:0] rd, exp; logic en, dr; int cnt; bit to;
    enable = 1'b1;
    local_push(8'hA5);
    local_push(8'h3C);
    compared++; if (int'(fifoCount) !== model_q.size()) begin mismatched++; $display("FAIL d2m_fill_count: got %0d expected %0d", fifoCount, model_q.size()); end
    for (int i = 0; i < 2; i++) begin
      exp = model_q.pop_front();
      dma_cycle(0, 0, 8'h00, rd, en, dr, cnt, to);
      compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL d2m_timeout: got timeout expected DREQ"); end
      compared++; if (rd !== exp) begin mismatched++; $display("FAIL d2m_data: got %h expected %h", rd, exp); end
      compared++; if (en !== 1'b1) begin mismatched++; $display("FAIL d2m_outen: got %b expected 1", en); end
      compared++; if (dr !== 1'b0) begin mismatched++; $display("FAIL d2m_release_dreq: got %b expected 0", dr); end
      compared++; if (cnt !== model_q.size()) begin mismatched++; $display("FAIL d2m_count: got %0d expected %0d", cnt, model_q.size()); end
    end
    tick(); tick(); tick();
    compared++; if (DREQ !== 1'b0) begin mismatched++; $display("FAIL d2m_empty_dreq: got %b expected 0", DREQ); end
    enable = 1'b0;
  endtask

  task automatic test_mem2dev_fill();
    logic [7:0] rd, wd; logic en, dr; int cnt; bit to;
    set_dir(1'b1);
    enable = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wd = 8'(8'h10 + i);
      dma_cycle(0, 0, wd, rd, en, dr, cnt, to);
      model_q.push_back(wd);
      compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL m2d_timeout: got timeout expected DREQ"); end
      compared++; if (en !== 1'b0) begin mismatched++; $display("FAIL m2d_outen: got %b expected 0", en); end
      compared++; if (dr !== 1'b0) begin mismatched++; $display("FAIL m2d_release_dreq: got %b expected 0", dr); end
      compared++; if (cnt !== model_q.size()) begin mismatched++; $display("FAIL m2d_count: got %0d expected %0d", cnt, model_q.size()); end
    end
    tick(); tick(); tick();
    compared++; if (DREQ !== 1'b0) begin mismatched++; $display("FAIL m2d_full_dreq: got %b expected 0", DREQ); end
    compared++; if (devInReady !== 1'b0) begin mismatched++; $display("FAIL m2d_inready: got %b expected 0", devInReady); end
    enable = 1'b0;
    devOutReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      compared++; if (devOutValid !== 1'b1) begin mismatched++; $display("FAIL m2d_outvalid: got %b expected 1", devOutValid); end
      compared++; if (devOutData !== model_q[0]) begin mismatched++; $display("FAIL m2d_outdata: got %h expected %h", devOutData, model_q[0]); end
      tick();
      void'(model_q.pop_front());
    end
    devOutReady = 1'b0;
    compared++; if (fifoCount !== 4'd0) begin mismatched++; $display("FAIL m2d_drained: got %0d expected 0", fifoCount); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] rd, exp, nb; logic en, dr; int cnt; bit to;
    set_dir(1'b0);
    for (int i = 0; i < 4; i++) local_push(8'($urandom));
    enable = 1'b1;
    nb  = 8'($urandom);
    exp = model_q.pop_front();
    dma_cycle(0, 1, nb, rd, en, dr, cnt, to);
    model_q.push_back(nb);
    compared++; if (to !== 1'b0) begin mismatched++; $display("FAIL sim_timeout: got timeout expected DREQ"); end
    compared++; if (rd !== exp) begin mismatched++; $display("FAIL sim_data: got %h expected %h", rd, exp); end
    compared++; if (cnt !== model_q.size()) begin mismatched++; $display("FAIL sim_count: got %0d expected %0d", cnt, model_q.size()); end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      dma_cycle(0, 0, 8'h00, rd, en, dr, cnt, to);
      compared++; if (rd !== exp || to) begin mismatched++; $display("FAIL sim_order: got %h expected %h", rd, exp); end
    end
    enable = 1'b0;
  endtask

  task automatic test_terminal_count();
    logic [7:0] rd, exp; logic en, dr; int cnt; bit to;
    for (int i = 0; i < 3; i++) local_push(8'($urandom));
    enable = 1'b1;
    exp = model_q.pop_front();
    dma_cycle(0, 0, 8'h00, rd, en, dr, cnt, to);
    compared++; if (rd !== exp || to) begin mismatched++; $display("FAIL tc_first_data: got %h expected %h", rd, exp); end
    compared++; if (tcFlag !== 1'b0) begin mismatched++; $display("FAIL tc_early: got %b expected 0", tcFlag); end
    exp = model_q.pop_front();
    dma_cycle(1, 0, 8'h00, rd, en, dr, cnt, to);
    compared++; if (rd !== exp || to) begin mismatched++; $display("FAIL tc_second_data: got %h expected %h", rd, exp); end
    compared++; if (tcFlag !== 1'b1) begin mismatched++; $display("FAIL tc_set: got %b expected 1", tcFlag); end
    tick(); tick(); tick(); tick();
    compared++; if (DREQ !== 1'b0) begin mismatched++; $display("FAIL tc_blocks_req: got %b expected 0", DREQ); end
    compared++; if (int'(fifoCount) !== model_q.size()) begin mismatched++; $display("FAIL tc_count: got %0d expected %0d", fifoCount, model_q.size()); end
    tcClear = 1'b1;
    tick();
    tcClear = 1'b0;
    compared++; if (tcFlag !== 1'b0) begin mismatched++; $display("FAIL tc_clear: got %b expected 0", tcFlag); end
    tick();
    compared++; if (DREQ !== 1'b1) begin mismatched++; $display("FAIL tc_req_resume: got %b expected 1", DREQ); end
    exp = model_q.pop_front();
    dma_cycle(0, 0, 8'h00, rd, en, dr, cnt, to);
    compared++; if (rd !== exp || to) begin mismatched++; $display("FAIL tc_third_data: got %h expected %h", rd, exp); end
    enable = 1'b0;
    DACK = 4'b0001; EOP_N = 1'b0; tcClear = 1'b1;
    tick();
    DACK = 4'b0000; EOP_N = 1'b1; tcClear = 1'b0;
    compared++; if (tcFlag !== 1'b1) begin mismatched++; $display("FAIL tc_set_wins: got %b expected 1", tcFlag); end
    tcClear = 1'b1;
    tick();
    tcClear = 1'b0;
    compared++; if (tcFlag !== 1'b0) begin mismatched++; $display("FAIL tc_reclear: got %b expected 0", tcFlag); end
  endtask

  task automatic test_wrong_channel();
    logic [7:0] rd, exp; logic en, dr; int cnt; bit to;
    bit saw_en = 0;
    for (int i = 0; i < 2; i++) local_push(8'($urandom));
    enable = 1'b1;
    tick();
    DACK = 4'b0010; IOR_N = 1'b0;
    tick();
    saw_en = busDataOutEn;
    tick();
    saw_en = saw_en | busDataOutEn;
    IOR_N = 1'b1;
    tick(); tick();
    DACK = 4'b0000;
    compared++; if (saw_en !== 1'b0) begin mismatched++; $display("FAIL wch_outen: got %b expected 0", saw_en); end
    compared++; if (int'(fifoCount) !== model_q.size()) begin mismatched++; $display("FAIL wch_count: got %0d expected %0d", fifoCount, model_q.size()); end
    compared++; if (DREQ !== 1'b1) begin mismatched++; $display("FAIL wch_dreq: got %b expected 1", DREQ); end
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      dma_cycle(0, 0, 8'h00, rd, en, dr, cnt, to);
      compared++; if (rd !== exp || to) begin mismatched++; $display("FAIL wch_drain: got %h expected %h", rd, exp); end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    int n = 0;
    for (int i = 0; i < 3; i++) local_push(8'($urandom));
    enable = 1'b1;
    while (!DREQ && n < 20) begin
      tick();
      n++;
    end
    compared++; if (DREQ !== 1'b1) begin mismatched++; $display("FAIL rst_pre_dreq: got %b expected 1", DREQ); end
    DACK = 4'b0001; IOR_N = 1'b0; EOP_N = 1'b0;
    tick();
    EOP_N = 1'b1;
    compared++; if (tcFlag !== 1'b1) begin mismatched++; $display("FAIL rst_pre_tc: got %b expected 1", tcFlag); end
    #2;
    RESET = 1'b1;
    #1;
    compared++; if (DREQ !== 1'b0) begin mismatched++; $display("FAIL rst_async_dreq: got %b expected 0", DREQ); end
    tick();
    compared++; if (fifoCount !== 4'd0) begin mismatched++; $display("FAIL rst_count: got %0d expected 0", fifoCount); end
    compared++; if (tcFlag !== 1'b0) begin mismatched++; $display("FAIL rst_tc: got %b expected 0", tcFlag); end
    compared++; if (busDataOutEn !== 1'b0) begin mismatched++; $display("FAIL rst_outen: got %b expected 0", busDataOutEn); end
    DACK = 4'b0000; IOR_N = 1'b1; enable = 1'b0;
    model_q.delete();
    RESET = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [7:0] rd, exp, wd; logic en, dr; int cnt, n; bit to, d;
    for (int r = 0; r < 6; r++) begin
      d = 1'($urandom_range(0, 1));
      n = $urandom_range(1, DEPTH);
      set_dir(d);
      if (d == 1'b0) begin
        for (int i = 0; i < n; i++) local_push(8'($urandom));
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
          exp = model_q.pop_front();
          dma_cycle(0, 0, 8'h00, rd, en, dr, cnt, to);
          compared++; if (rd !== exp || to) begin mismatched++; $display("FAIL rnd_d2m_data: got %h expected %h", rd, exp); end
        end
        enable = 1'b0;
      end else begin
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
          wd = 8'($urandom);
          dma_cycle(0, 0, wd, rd, en, dr, cnt, to);
          model_q.push_back(wd);
          compared++; if (cnt !== model_q.size() || to) begin mismatched++; $display("FAIL rnd_m2d_count: got %0d expected %0d", cnt, model_q.size()); end
        end
        enable = 1'b0;
        devOutReady = 1'b1;
        for (int i = 0; i < n; i++) begin
          exp = model_q.pop_front();
          compared++; if (devOutValid !== 1'b1 || devOutData !== exp) begin mismatched++; $display("FAIL rnd_m2d_data: got %h valid %b expected %h", devOutData, devOutValid, exp); end
          tick();
        end
        devOutReady = 1'b0;
      end
      compared++; if (fifoCount !== 4'd0) begin mismatched++; $display("FAIL rnd_end_count: got %0d expected 0", fifoCount); end
    end
  endtask

  initial begin
    test_reset();
    test_dev2mem();
    test_mem2dev_fill();
    test_simultaneous();
    test_terminal_count();
    test_wrong_channel();
    test_reset_mid_xfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dma_periph_endpoint.md
Name: dma_periph_endpoint

Overview:
- Peripheral-side endpoint of the DREQ/DACK single-transfer protocol driven by the DMA controller.
- Buffers bytes between a local device stream and the DMA data bus.
- Raises DREQ for its channel, answers DACK-qualified IOR_N/IOW_N strobes, and records terminal count from EOP_N.
- One instance per DMA-capable peripheral; its DREQ drives DREQ[CHANNEL] at the top level.

Parameters:
- DEPTH, 8, FIFO depth in bytes (power of two, >=2)
- CHANNEL, 0, DMA channel index 0..3 used to select this endpoint's DACK bit

Ports:
- CLK  input  1  system clock; all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- enable  input  1  endpoint may request service
- dirIn  input  1  0 = device-to-memory (DMA I/O read), 1 = memory-to-device (DMA I/O write)
- DREQ  output  1  DMA request for CHANNEL
- DACK  input  4  DMA acknowledge, active-high, one-hot
- IOR_N  input  1  I/O read strobe, active-low
- IOW_N  input  1  I/O write strobe, active-low
- EOP_N  input  1  end of process, active-low
- busDataIn  input  8  DMA data bus value during IOW_N
- busDataOut  output  8  byte driven during IOR_N
- busDataOutEn  output  1  drive enable for busDataOut
- devInValid / devInReady / devInData  in/out/in  1/1/8  local producer stream (device-to-memory)
- devOutValid / devOutReady / devOutData  out/in/out  1/1/8  local consumer stream (memory-to-device)
- tcFlag  output  1  sticky terminal-count indication
- tcClear  input  1  clears tcFlag
- fifoCount  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values: DREQ=0, busDataOutEn=0, busDataOut=0, tcFlag=0, fifoCount=0, devInReady=0, devOutValid=0, state=IDLE, latched dir=0.
- ack = DACK[CHANNEL]. A strobe is active when ack=1 and the strobe for the latched dir is low (IOR_N for dir 0, IOW_N for dir 1).
- dir latching: dirIn is copied into the latched dir only when state=IDLE and fifoCount=0. Changes at any other time are ignored until that condition holds.
- FSM states:
  - IDLE: go to REQ when enable && !tcFlag && ready, where ready = (dir 0: count>=1; dir 1: count<DEPTH).
  - REQ: DREQ=1 (registered). Go to XFER when ack=1 and the strobe is low.
  - XFER: commit on the strobe's rising edge (sampled low last cycle, high now, ack=1), then go to RELEASE.
  - RELEASE: DREQ=0. Go to IDLE when ack=0.
  - ack dropping in REQ/XFER without a strobe edge: no commit; return to IDLE next cycle.
- Commit, dir 0:
  - While strobe low, busDataOutEn=1 and busDataOut=FIFO head (combinational from the head register).
  - Pop on commit.
- Commit, dir 1:
  - busDataIn is captured every cycle the strobe is low; the last captured value is pushed on commit.
  - busDataOutEn stays 0.
- Local side:
  - devInReady = (dir=0 && count<DEPTH).
  - devOutValid = (dir=1 && count>0); devOutData = head.
  - A local push or pop in the same cycle as a DMA commit is legal; count nets correctly (push+pop leaves it unchanged).
- DREQ at the boundaries:
  - DREQ is never 1 when dir 0 with count=0, or dir 1 with count=DEPTH, except during the strobe cycle that empties or fills the FIFO.
  - Minimum DREQ deassertion is one cycle (RELEASE) between transfers.
- Terminal count:
  - EOP_N=0 while ack=1 sets tcFlag on the next edge.
  - tcClear clears tcFlag; if set and clear happen in the same cycle, set wins.
  - While tcFlag=1, no new REQ; a transfer already in progress completes.
- Pointers wrap modulo DEPTH.
- Reset mid-transfer: FIFO is flushed, DREQ drops immediately (asynchronous), and the endpoint returns to IDLE.

Decomposition:
- Package dma_periph_pkg: state enum {IDLE, REQ, XFER, RELEASE} (one-hot encoding, matching the timing-and-control style); DIR_DEV2MEM / DIR_MEM2DEV constants.
- Sub-module dma_periph_fifo: sync FIFO with push, pop, head, count, full, empty; single push and single pop per cycle.

Test Plan:
- Reset asserted mid-XFER with count=3 -> same cycle DREQ=0; next edge fifoCount=0, tcFlag=0, busDataOutEn=0.
- dir 0: push 0xA5, 0x3C locally; DACK=4'b0001, IOR_N low 2 cycles then high, repeated twice -> busDataOut=0xA5 then 0x3C with OutEn during each strobe; DREQ drops in RELEASE; count 2->1->0; DREQ stays 0 afterwards.
- dir 1, DEPTH=8: eight IOW_N strobes with busDataIn=0x10..0x17 -> count=8, DREQ=0 after the eighth commit; devOut pops deliver 0x10..0x17 in order.
- Simultaneous local push and DMA pop at count=4 -> count stays 4, data order preserved.
- EOP_N low with DACK=4'b0001 on the second transfer -> tcFlag=1; DREQ is not reasserted despite data; tcClear pulse -> DREQ returns next cycle.
- DACK=4'b0010 with CHANNEL=0 and IOR_N low -> no commit, busDataOutEn=0, count unchanged.
